// File: rtl/shift_seq_ctrl.sv
// Sequencer feeding a right-shift register one bit per bit-period.
// A word is accepted via valid/ready in IDLE, the register is cleared for
// one cycle, then WIDTH bits go out on ser_out with one shift_en strobe per
// bit-period, followed by a one-cycle done pulse.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       msb_first,
  input  logic                       abort,
  output logic                       load_ready,
  output logic                       sr_clr,
  output logic                       shift_en,
  output logic                       ser_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] word_q, word_n;
  logic             msb_q, msb_n;
  logic [DW-1:0]    div_q, div_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             sr_clr_q, shift_q, done_q, busy_q, ser_q;
  logic             ser_n;
  logic [WIDTH-1:0] sh_l, sh_r;
  logic             kill;

  // abort and rst cancel the cycle's strobes immediately, not one edge later
  assign kill = abort | rst;

  // Next-state, counter and next-serial-bit computation
  always_comb begin
    state_n = state;
    word_n  = word_q;
    msb_n   = msb_q;
    div_n   = div_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_n = CLEAR;
          word_n  = load_data;
          msb_n   = msb_first;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        state_n = SHIFT;
        div_n   = '0;
        cnt_n   = '0;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_n = '0;
          cnt_n = cnt_q + CW'(1);
          if (cnt_q == BIT_LAST) state_n = DONE;
        end else begin
          div_n = div_q + DW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      word_n  = word_q;
      msb_n   = msb_q;
      div_n   = '0;
      cnt_n   = cnt_q;
    end
    // Shifting instead of indexing keeps the bit select in range when cnt_n==WIDTH
    sh_l  = word_n << cnt_n;
    sh_r  = word_n >> cnt_n;
    ser_n = (state_n == SHIFT) & (msb_n ? sh_l[WIDTH-1] : sh_r[0]);
  end

  // State, datapath registers and registered outputs decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_q   <= '0;
      msb_q    <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      sr_clr_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ser_q    <= 1'b0;
    end else begin
      state    <= state_n;
      word_q   <= word_n;
      msb_q    <= msb_n;
      div_q    <= div_n;
      cnt_q    <= cnt_n;
      sr_clr_q <= (state_n == CLEAR);
      shift_q  <= (state_n == SHIFT) && (div_n == DIV_LAST);
      done_q   <= (state_n == DONE);
      busy_q   <= (state_n == CLEAR) || (state_n == SHIFT);
      ser_q    <= ser_n;
    end
  end

  assign load_ready = (state == IDLE) & ~rst;
  assign sr_clr     = sr_clr_q & ~kill;
  assign shift_en   = shift_q & ~kill;
  assign done       = done_q & ~kill;
  assign busy       = busy_q;
  assign ser_out    = ser_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two lanes (DIV=1 and DIV=3), each with its own
// downstream right-shift register, stimulus process and scoreboard monitor.
module tb_shift_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic         msb;
    logic         ends;   // 1: word is expected to complete with done
    logic [15:0]  gap;    // nonzero: accept must follow previous accept by exactly gap cycles
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit fin [2];

  function automatic void chk(int lane, bit ok, string name, int act, int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h", lane, name, act, exp);
    end
  endfunction

  // k-th bit sent on the serial line for a word
  function automatic logic exp_bit(item_t it, int unsigned k);
    logic [W-1:0] l, r;
    if (k >= W) return 1'b0;
    l = it.data << k;
    r = it.data >> k;
    return it.msb ? l[W-1] : r[0];
  endfunction

  // final register contents: data itself for LSB-first, bit-reversed for MSB-first
  function automatic logic [W-1:0] exp_reg(item_t it);
    logic [W-1:0] r;
    r = {<<{it.data}};
    return it.msb ? r : it.data;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D = (g == 0) ? 1 : 3;

    logic          rst, load_valid, msb_first, abort;
    logic [W-1:0]  load_data;
    logic          load_ready, sr_clr, shift_en, ser_out, busy, done;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  sreg;

    item_t       q[$];
    bit          active    = 1'b0;
    bit          have_prev = 1'b0;
    int unsigned cyc       = 0;
    int unsigned hs        = 0;
    int unsigned prev_hs   = 0;

    shift_seq_ctrl #(.WIDTH(W), .DIV(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_data (load_data),
      .msb_first (msb_first),
      .abort     (abort),
      .load_ready(load_ready),
      .sr_clr    (sr_clr),
      .shift_en  (shift_en),
      .ser_out   (ser_out),
      .busy      (busy),
      .done      (done),
      .bit_cnt   (bit_cnt)
    );

    always @(posedge clk) begin
      if (rst || sr_clr) sreg <= '0;
      else if (shift_en) sreg <= {ser_out, sreg[W-1:1]};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every cycle of an active word against the timing model
    always @(negedge clk) begin
      item_t        it;
      int unsigned  o, k;
      logic [4:0]   ev, av;
      if (rst || abort) begin
        if (active) begin
          it = q.pop_front();
          chk(g, it.ends == 1'b0, "unplanned_cancel", int'(it.ends), 0);
          chk(g, {shift_en, sr_clr, done} == 3'b000, "cancel_strobes",
              int'({shift_en, sr_clr, done}), 0);
          active = 1'b0;
        end
      end else if (active) begin
        it = q[0];
        o  = cyc - hs;
        av = {sr_clr, shift_en, done, busy, ser_out};
        if (o == 1) begin
          chk(g, av[4:1] == 4'b1001, "clear_cycle", int'(av[4:1]), 9);
          chk(g, bit_cnt == '0, "clear_bitcnt", int'(bit_cnt), 0);
        end else if (o <= 1 + W * D) begin
          k  = (o - 2) / D;
          ev = {1'b0, ((o - 1) % D) == 0, 1'b0, 1'b1, exp_bit(it, k)};
          chk(g, av == ev, "shift_cycle", int'(av), int'(ev));
          chk(g, int'(bit_cnt) == int'(k), "shift_bitcnt", int'(bit_cnt), int'(k));
        end else begin
          chk(g, av == 5'b00100, "done_cycle", int'(av), 4);
          chk(g, sreg == exp_reg(it), "final_reg", int'(sreg), int'(exp_reg(it)));
          chk(g, int'(bit_cnt) == W, "done_bitcnt", int'(bit_cnt), W);
          void'(q.pop_front());
          active = 1'b0;
        end
      end else begin
        chk(g, {sr_clr, shift_en, done, busy} == 4'b0000, "idle_quiet",
            int'({sr_clr, shift_en, done, busy}), 0);
      end
      if (load_valid && load_ready && !abort && !rst) begin
        if (active || q.size() == 0) begin
          chk(g, 1'b0, "unexpected_accept", int'(active), 0);
        end else begin
          if (q[0].gap != 0 && have_prev)
            chk(g, (cyc - prev_hs) == int'(q[0].gap), "accept_gap",
                int'(cyc - prev_hs), int'(q[0].gap));
          active    = 1'b1;
          hs        = cyc;
          prev_hs   = cyc;
          have_prev = 1'b1;
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic m, input logic ends,
                        input int unsigned gap, input bit keep);
      item_t it;
      bit    acc = 1'b0;
      it.data = d;
      it.msb  = m;
      it.ends = ends;
      it.gap  = 16'(gap);
      q.push_back(it);
      load_data  = d;
      msb_first  = m;
      load_valid = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
        @(negedge clk);
        acc = load_ready && !abort;
        step();
      end
      if (!acc) chk(g, 1'b0, "accept_timeout", 0, 1);
      if (!keep) load_valid = 1'b0;
    endtask

    task automatic wait_idle();
      for (int i = 0; i < 300 && q.size() != 0; i++) step();
      chk(g, q.size() == 0, "drain", q.size(), 0);
      step();
    endtask

    // Stimulus: reset, directed scenarios, then random words
    initial begin
      logic [W-1:0] d;
      rst = 1'b1; load_valid = 1'b0; load_data = '0; msb_first = 1'b0; abort = 1'b0;
      step();
      @(negedge clk);
      chk(g, load_ready == 1'b0, "ready_in_rst", int'(load_ready), 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk(g, load_ready == 1'b1, "reset_ready", int'(load_ready), 1);
      chk(g, {busy, done, shift_en, sr_clr, ser_out} == 5'b0, "reset_outs",
          int'({busy, done, shift_en, sr_clr, ser_out}), 0);
      chk(g, bit_cnt == '0, "reset_bitcnt", int'(bit_cnt), 0);
      step();

      // 1011: LSB-first on the DIV=1 lane, MSB-first on the DIV=3 lane
      send(4'b1011, (g == 1), 1'b1, 0, 1'b0);
      wait_idle();

      // abort in the cycle after the 2nd shift_en, then a normal word
      send(4'b0110, 1'b0, 1'b0, 0, 1'b0);
      repeat (1 + 2 * D) step();
      abort = 1'b1;
      @(negedge clk);
      step();
      abort = 1'b0;
      @(negedge clk);
      chk(g, load_ready == 1'b1, "ready_after_abort", int'(load_ready), 1);
      step();
      send(4'b1001, 1'b1, 1'b1, 0, 1'b0);
      wait_idle();

      // abort in IDLE with a word offered must not accept it
      load_valid = 1'b1; load_data = 4'b1111; abort = 1'b1;
      @(negedge clk);
      step();
      load_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk(g, busy == 1'b0, "no_accept_on_abort", int'(busy), 0);
      step();

      // back-to-back words with load_data changed mid-word
      d = W'($urandom);
      send(d, 1'($urandom_range(0, 1)), 1'b1, 0, 1'b1);
      send(~d, 1'($urandom_range(0, 1)), 1'b1, W * D + 3, 1'b0);
      wait_idle();

      // rst in the middle of SHIFT
      send(4'b1101, 1'b1, 1'b0, 0, 1'b0);
      repeat (2 + D) step();
      rst = 1'b1;
      @(negedge clk);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk(g, bit_cnt == '0, "rst_bitcnt", int'(bit_cnt), 0);
      chk(g, load_ready == 1'b1, "rst_ready", int'(load_ready), 1);
      chk(g, {busy, done} == 2'b00, "rst_quiet", int'({busy, done}), 0);
      step();

      // random words with random idle gaps
      for (int n = 0; n < 12; n++) begin
        repeat ($urandom_range(0, 3)) step();
        send(W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
      end
      wait_idle();
      fin[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(fin[0] && fin[1]); i++) @(posedge clk);
    if (!(fin[0] && fin[1])) chk(-1, 1'b0, "run_timeout", int'({fin[0], fin[1]}), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
